// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a read FIFO and a write FIFO using round-robin arbitration.
// Optional build macro: MEM_ARB_PERF_EN adds saturating performance counters.
// Ports:
//   i_clk, i_rst_n                         clock, asynchronous active-low reset
//   i_ld_en/i_ld_addr/i_ld_control         read request enqueue; o_ld_full read FIFO full
//   i_st_en/i_st_addr/i_st_control/i_st_data write request enqueue; o_st_full write FIFO full
//   o_mem_en/o_mem_rdwr/o_mem_addr/o_mem_control/o_mem_wdata, i_mem_ready  registered memory request
//   i_mem_rvalid/i_mem_rdata -> o_ld_rvalid/o_ld_rdata  read response, one cycle later
//   o_ovf_err, o_rsp_err                   sticky error flags
//   o_perf_rd_cnt/o_perf_wr_cnt/o_perf_stall_cnt  (MEM_ARB_PERF_EN only)
module mem_port_arbiter #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ld_en,
    input  logic [31:0]  i_ld_addr,
    input  logic [4:0]   i_ld_control,
    output logic         o_ld_full,
    input  logic         i_st_en,
    input  logic [31:0]  i_st_addr,
    input  logic [4:0]   i_st_control,
    input  logic [127:0] i_st_data,
    output logic         o_st_full,
    output logic         o_mem_en,
    output logic         o_mem_rdwr,
    output logic [31:0]  o_mem_addr,
    output logic [4:0]   o_mem_control,
    output logic [127:0] o_mem_wdata,
    input  logic         i_mem_ready,
    input  logic         i_mem_rvalid,
    input  logic [127:0] i_mem_rdata,
    output logic         o_ld_rvalid,
    output logic [127:0] o_ld_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]  o_perf_rd_cnt,
    output logic [31:0]  o_perf_wr_cnt,
    output logic [31:0]  o_perf_stall_cnt,
`endif
    output logic         o_ovf_err,
    output logic         o_rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_ONE  = 1;
    localparam logic [AW-1:0] L_PONE = 1;
    localparam logic [3:0]    L_MAX  = 4'(MAX_OUT);
    localparam logic [0:0]    OUT_IDLE = 1'b0;
    localparam logic [0:0]    OUT_HOLD = 1'b1;

    logic [31:0]  r_ld_addr_q [DEPTH];
    logic [4:0]   r_ld_ctl_q  [DEPTH];
    logic [31:0]  r_st_addr_q [DEPTH];
    logic [4:0]   r_st_ctl_q  [DEPTH];
    logic [127:0] r_st_data_q [DEPTH];
    logic [AW-1:0] r_ld_wp, r_ld_rp, r_st_wp, r_st_rp;
    logic [AW:0]   r_ld_cnt, r_st_cnt;
    logic          r_ld_full, r_st_full;
    logic [0:0]    r_state;
    logic          r_rr;
    logic [3:0]    r_out;
    logic          r_mem_rdwr;
    logic [31:0]   r_mem_addr;
    logic [4:0]    r_mem_ctl;
    logic [127:0]  r_mem_wdata;
    logic          r_ld_rvalid;
    logic [127:0]  r_ld_rdata;
    logic          r_ovf_err, r_rsp_err;

    logic          w_ld_push, w_st_push, w_hold_done, w_can_load, w_rr_eff;
    logic          w_rd_elig, w_wr_elig, w_pick_rd, w_pick_wr, w_rd_done, w_rsp_ok;
    logic [3:0]    w_out_eff;
    logic [AW:0]   w_ld_cnt_nxt, w_st_cnt_nxt;

    always_comb begin
        w_ld_push    = i_ld_en && (r_ld_cnt != L_FULL);
        w_st_push    = i_st_en && (r_st_cnt != L_FULL);
        w_hold_done  = (r_state == OUT_HOLD) && i_mem_ready;
        w_rd_done    = w_hold_done && !r_mem_rdwr;
        w_can_load   = (r_state == OUT_IDLE) || w_hold_done;
        // A read completing this cycle already occupies a slot when judging the next candidate.
        w_out_eff    = r_out + (w_rd_done ? 4'd1 : 4'd0);
        w_rr_eff     = w_hold_done ? ~r_mem_rdwr : r_rr;
        w_rd_elig    = (r_ld_cnt != '0) && (w_out_eff < L_MAX);
        w_wr_elig    = r_st_cnt != '0;
        w_pick_rd    = w_can_load && w_rd_elig && (!w_wr_elig || !w_rr_eff);
        w_pick_wr    = w_can_load && w_wr_elig && !w_pick_rd;
        w_rsp_ok     = i_mem_rvalid && (r_out != 4'd0);
        w_ld_cnt_nxt = (w_ld_push && !w_pick_rd) ? r_ld_cnt + L_ONE :
                       (!w_ld_push && w_pick_rd) ? r_ld_cnt - L_ONE : r_ld_cnt;
        w_st_cnt_nxt = (w_st_push && !w_pick_wr) ? r_st_cnt + L_ONE :
                       (!w_st_push && w_pick_wr) ? r_st_cnt - L_ONE : r_st_cnt;
    end

    // FIFO storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge i_clk) begin
        if (w_ld_push) begin
            r_ld_addr_q[r_ld_wp] <= i_ld_addr;
            r_ld_ctl_q[r_ld_wp]  <= i_ld_control;
        end
        if (w_st_push) begin
            r_st_addr_q[r_st_wp] <= i_st_addr;
            r_st_ctl_q[r_st_wp]  <= i_st_control;
            r_st_data_q[r_st_wp] <= i_st_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_wp     <= '0;
            r_ld_rp     <= '0;
            r_st_wp     <= '0;
            r_st_rp     <= '0;
            r_ld_cnt    <= '0;
            r_st_cnt    <= '0;
            r_ld_full   <= 1'b0;
            r_st_full   <= 1'b0;
            r_state     <= OUT_IDLE;
            r_rr        <= 1'b0;
            r_out       <= 4'd0;
            r_mem_rdwr  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_ctl   <= '0;
            r_mem_wdata <= '0;
            r_ld_rvalid <= 1'b0;
            r_ld_rdata  <= '0;
            r_ovf_err   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_ld_push) r_ld_wp <= r_ld_wp + L_PONE;
            if (w_st_push) r_st_wp <= r_st_wp + L_PONE;
            if (w_pick_rd) r_ld_rp <= r_ld_rp + L_PONE;
            if (w_pick_wr) r_st_rp <= r_st_rp + L_PONE;
            r_ld_cnt  <= w_ld_cnt_nxt;
            r_st_cnt  <= w_st_cnt_nxt;
            r_ld_full <= w_ld_cnt_nxt == L_FULL;
            r_st_full <= w_st_cnt_nxt == L_FULL;
            if ((i_ld_en && !w_ld_push) || (i_st_en && !w_st_push)) r_ovf_err <= 1'b1;
            if (i_mem_rvalid && (r_out == 4'd0)) r_rsp_err <= 1'b1;
            if (w_hold_done) r_rr <= ~r_mem_rdwr;
            r_state <= (w_pick_rd || w_pick_wr) ? OUT_HOLD : w_hold_done ? OUT_IDLE : r_state;
            if (w_pick_rd || w_pick_wr) begin
                r_mem_rdwr  <= w_pick_wr;
                r_mem_addr  <= w_pick_wr ? r_st_addr_q[r_st_rp] : r_ld_addr_q[r_ld_rp];
                r_mem_ctl   <= w_pick_wr ? r_st_ctl_q[r_st_rp]  : r_ld_ctl_q[r_ld_rp];
                r_mem_wdata <= w_pick_wr ? r_st_data_q[r_st_rp] : '0;
            end
            r_out <= r_out + (w_rd_done ? 4'd1 : 4'd0) - (w_rsp_ok ? 4'd1 : 4'd0);
            r_ld_rvalid <= w_rsp_ok;
            if (w_rsp_ok) r_ld_rdata <= i_mem_rdata;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_rd, r_perf_wr, r_perf_stall;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_rd    <= '0;
            r_perf_wr    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_rd_done && r_perf_rd != '1) r_perf_rd <= r_perf_rd + 32'd1;
            if (w_hold_done && r_mem_rdwr && r_perf_wr != '1) r_perf_wr <= r_perf_wr + 32'd1;
            if ((r_state == OUT_HOLD) && !i_mem_ready && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
    assign o_perf_rd_cnt    = r_perf_rd;
    assign o_perf_wr_cnt    = r_perf_wr;
    assign o_perf_stall_cnt = r_perf_stall;
`endif

    assign o_ld_full     = r_ld_full;
    assign o_st_full     = r_st_full;
    assign o_mem_en      = r_state == OUT_HOLD;
    assign o_mem_rdwr    = r_mem_rdwr;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_control = r_mem_ctl;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_ld_rvalid   = r_ld_rvalid;
    assign o_ld_rdata    = r_ld_rdata;
    assign o_ovf_err     = r_ovf_err;
    assign o_rsp_err     = r_rsp_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (DEPTH=4, MAX_OUT=4).
module tb_mem_port_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ld_en = 1'b0;
    logic [31:0]  ld_addr = '0;
    logic [4:0]   ld_control = '0;
    logic         ld_full;
    logic         st_en = 1'b0;
    logic [31:0]  st_addr = '0;
    logic [4:0]   st_control = '0;
    logic [127:0] st_data = '0;
    logic         st_full;
    logic         mem_en, mem_rdwr;
    logic [31:0]  mem_addr;
    logic [4:0]   mem_control;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         ld_rvalid;
    logic [127:0] ld_rdata;
    logic         ovf_err, rsp_err;
    int           n_chk = 0;
    int           n_fail = 0;

    mem_port_arbiter #(.DEPTH(4), .MAX_OUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_control(ld_control), .o_ld_full(ld_full),
        .i_st_en(st_en), .i_st_addr(st_addr), .i_st_control(st_control), .i_st_data(st_data), .o_st_full(st_full),
        .o_mem_en(mem_en), .o_mem_rdwr(mem_rdwr), .o_mem_addr(mem_addr), .o_mem_control(mem_control),
        .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_ld_rvalid(ld_rvalid), .o_ld_rdata(ld_rdata),
        .o_ovf_err(ovf_err), .o_rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_rdwr", mem_rdwr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_ctl", mem_control, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ld_rvalid", ld_rvalid, 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        chk("rst_full", {ld_full, st_full}, 0);
        chk("rst_err", {ovf_err, rsp_err}, 0);
        rst_n = 1'b1;

        // single write, two-cycle latency, one-cycle pulse
        mem_ready = 1'b1;
        st_en = 1'b1; st_addr = 32'h100; st_control = 5'd16; st_data = {16{8'hA5}};
        step();
        st_en = 1'b0;
        chk("w1_lat1_en", mem_en, 0);
        step();
        chk("w1_en", mem_en, 1);
        chk("w1_rdwr", mem_rdwr, 1);
        chk("w1_addr", mem_addr, 32'h100);
        chk("w1_ctl", mem_control, 16);
        chk("w1_wdata", mem_wdata, {16{8'hA5}});
        step();
        chk("w1_pulse_end", mem_en, 0);

        // alternation R,W,R,W with no bubbles
        mem_ready = 1'b0;
        ld_en = 1'b1; ld_addr = 32'h1000; ld_control = 5'd16;
        st_en = 1'b1; st_addr = 32'h2000; st_control = 5'd8; st_data = 128'hD0D0;
        step();
        ld_addr = 32'h1010; st_addr = 32'h2010; st_data = 128'hD1D1;
        step();
        ld_en = 1'b0; st_en = 1'b0;
        chk("alt0_en", mem_en, 1);
        chk("alt0_rdwr", mem_rdwr, 0);
        chk("alt0_addr", mem_addr, 32'h1000);
        chk("alt0_wdata", mem_wdata, 0);
        step();
        chk("alt0_stall_addr", {mem_en, mem_addr}, {1'b1, 32'h1000});
        mem_ready = 1'b1;
        step();
        chk("alt1", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b1, 32'h2000});
        chk("alt1_wdata", mem_wdata, 128'hD0D0);
        step();
        chk("alt2", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b0, 32'h1010});
        step();
        chk("alt3", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b1, 32'h2010});
        step();
        chk("alt_done", mem_en, 0);

        // read responses for the two reads, then a stray response
        mem_rvalid = 1'b1; mem_rdata = 128'hCAFE_0001;
        step();
        chk("rsp1_valid", ld_rvalid, 1);
        chk("rsp1_data", ld_rdata, 128'hCAFE_0001);
        mem_rdata = 128'hCAFE_0002;
        step();
        chk("rsp2_valid", ld_rvalid, 1);
        chk("rsp2_data", ld_rdata, 128'hCAFE_0002);
        mem_rvalid = 1'b0;
        step();
        chk("rsp_idle", {ld_rvalid, rsp_err}, 0);
        mem_rvalid = 1'b1; mem_rdata = 128'hBAD;
        step();
        mem_rvalid = 1'b0;
        chk("stray_rvalid", ld_rvalid, 0);
        chk("stray_rsp_err", rsp_err, 1);

        // write FIFO overflow with memory stalled
        mem_ready = 1'b0;
        st_control = 5'd4;
        for (int i = 0; i < 5; i++) begin
            st_en = 1'b1; st_addr = 32'h200 + 32'(16 * i);
            step();
            chk("ovf_full", st_full, (i == 4) ? 1 : 0);
        end
        chk("ovf_not_yet", ovf_err, 0);
        st_addr = 32'h250;
        step();
        st_en = 1'b0;
        chk("ovf_err", ovf_err, 1);
        chk("ovf_full_hold", st_full, 1);
        chk("ovf_head", {mem_en, mem_addr}, {1'b1, 32'h200});
        mem_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            chk("ovf_drain", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b1, 32'h200 + 32'(16 * k)});
            if (k == 1) chk("ovf_full_clr", st_full, 0);
        end
        step();
        chk("ovf_drain_end", mem_en, 0);

        // outstanding read limit
        ld_control = 5'd16;
        for (int i = 0; i < 6; i++) begin
            ld_en = 1'b1; ld_addr = 32'h3000 + 32'(64 * i);
            step();
            if (i >= 1 && i <= 4)
                chk("mo_issue", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b0, 32'h3000 + 32'(64 * (i - 1))});
            else
                chk("mo_idle", mem_en, 0);
        end
        ld_en = 1'b0;
        step();
        chk("mo_blocked", mem_en, 0);
        mem_rvalid = 1'b1; mem_rdata = 128'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("mo_rsp_valid", ld_rvalid, 1);
        chk("mo_rsp_data", ld_rdata, 128'h5555_AAAA);
        chk("mo_still_blocked", mem_en, 0);
        step();
        chk("mo_fifth", {mem_en, mem_addr}, {1'b1, 32'h3100});
        chk("mo_rvalid_drop", ld_rvalid, 0);
        step();
        chk("mo_sixth_blocked", mem_en, 0);

        // reset while a request is held
        mem_ready = 1'b0;
        st_en = 1'b1; st_addr = 32'h400;
        step();
        st_en = 1'b0;
        step();
        chk("mid_hold", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b1, 32'h400});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", mem_en, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_err", {ovf_err, rsp_err}, 0);
        chk("mid_rst_full", {ld_full, st_full}, 0);
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step();
        step();
        chk("post_rst_empty", mem_en, 0);
        ld_en = 1'b1; ld_addr = 32'h500;
        step();
        ld_en = 1'b0;
        step();
        chk("post_rst_read", {mem_en, mem_rdwr, mem_addr}, {1'b1, 1'b0, 32'h500});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
